// File: rtl/syscall_read_int_if.sv
// syscall_read_int_if: request, console byte handshake and result signals of the read-int syscall parser
interface syscall_read_int_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic             char_valid;
   logic [7:0]       char_data;
   logic             char_ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rd;
   logic             err;
   modport master (output start, char_valid, char_data, input char_ready, busy, done, rd, err);
   modport slave  (input start, char_valid, char_data, output char_ready, busy, done, rd, err);
endinterface

// File: rtl/syscall_read_int.sv
// syscall_read_int: parses an optionally signed decimal integer from the console byte stream and returns it saturated to WIDTH bits
module syscall_read_int #(
   parameter int WIDTH     = 32,
   parameter int MAX_CHARS = 16
) (
   input logic               clk,
   input logic               reset,
   syscall_read_int_if.slave bus
);
   localparam int CW = $clog2(MAX_CHARS + 1);
   localparam int AW = WIDTH + 4;
   localparam logic [AW-1:0] MIN_MAG = AW'(1) << (WIDTH - 1);
   typedef enum logic [2:0] {IDLE, SKIP, SIGN, DIGITS, FIN} state_e;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
   logic             perr_q, perr_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             accept, is_digit, is_blank, is_term, is_sign, fail, dig_ovf;
   logic [AW-1:0]    lim, sum;
   logic [WIDTH-1:0] acc_dig, signed_acc;
   assign accept     = bus.char_valid && ready_q;
   assign is_digit   = bus.char_data >= 8'h30 && bus.char_data <= 8'h39;
   assign is_blank   = bus.char_data == 8'h20 || bus.char_data == 8'h09;
   assign is_term    = bus.char_data == 8'h0a || bus.char_data == 8'h0d || bus.char_data == 8'h20;
   assign is_sign    = bus.char_data == 8'h2d || bus.char_data == 8'h2b;
   // a negative number may reach one more than the positive limit
   assign lim        = neg_q ? MIN_MAG : MIN_MAG - AW'(1);
   assign sum        = (AW'(acc_q) << 3) + (AW'(acc_q) << 1) + AW'(bus.char_data[3:0]);
   assign dig_ovf    = ovf_q || sum > lim;
   assign acc_dig    = dig_ovf ? lim[WIDTH-1:0] : sum[WIDTH-1:0];
   assign signed_acc = neg_q ? -acc_q : acc_q;
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      perr_d  = perr_q;
      rd_d    = rd_q;
      err_d   = err_q;
      done_d  = 1'b0;
      fail    = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = SKIP;
            acc_d   = '0;
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
         end
         SKIP: if (accept) begin
            if (is_digit) begin
               state_d = DIGITS;
               acc_d   = acc_dig;
               ovf_d   = dig_ovf;
            end else if (is_sign) begin
               state_d = SIGN;
               neg_d   = bus.char_data == 8'h2d;
            end else if (!is_blank) begin
               fail = 1'b1;
            end
         end
         SIGN: if (accept) begin
            if (is_digit) begin
               state_d = DIGITS;
               acc_d   = acc_dig;
               ovf_d   = dig_ovf;
            end else begin
               fail = 1'b1;
            end
         end
         DIGITS: if (accept) begin
            if (is_digit) begin
               acc_d = acc_dig;
               ovf_d = dig_ovf;
            end else if (is_term) begin
               state_d = FIN;
               res_d   = signed_acc;
               perr_d  = ovf_q;
            end else begin
               fail = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
            rd_d    = res_q;
            err_d   = perr_q;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (accept) cnt_d = cnt_q + CW'(1);
      // a byte that leaves the parse unfinished at the length limit ends the request
      if (fail || (accept && state_d != FIN && cnt_d == CW'(MAX_CHARS))) begin
         state_d = FIN;
         res_d   = '0;
         perr_d  = 1'b1;
      end
      busy_d  = state_d != IDLE;
      ready_d = state_d == SKIP || state_d == SIGN || state_d == DIGITS;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         perr_q  <= 1'b0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         perr_q  <= perr_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end
   assign bus.char_ready = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.rd         = rd_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_syscall_read_int.sv
// tb_syscall_read_int: directed and random console strings checked against a string-level parse model
module tb_syscall_read_int;
   localparam int MAXC = 16;
   typedef byte unsigned bq_t[$];
   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   syscall_read_int_if #(.WIDTH(32)) bus ();
   syscall_read_int #(.WIDTH(32), .MAX_CHARS(MAXC)) dut (.clk(clk), .reset(reset), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction
   // whole-string view: blanks, optional sign, digit run, then the byte that ends it
   function automatic void model(input bq_t s, output logic [31:0] r, output logic e, output int n);
      int          i;
      int          nd;
      bit          neg;
      longint      mag;
      longint      lim;
      byte unsigned c;
      i = 0; nd = 0; neg = 0; mag = 0;
      while (i < MAXC && i < s.size() && (s[i] == 8'h20 || s[i] == 8'h09)) i++;
      if (i < MAXC && i < s.size() && (s[i] == "-" || s[i] == "+")) begin
         neg = s[i] == "-";
         i++;
      end
      while (i < MAXC && i < s.size() && s[i] >= "0" && s[i] <= "9") begin
         mag = mag * 10 + longint'(s[i] - 8'h30);
         nd++;
         i++;
      end
      r = '0;
      e = 1'b1;
      n = MAXC;
      if (i < MAXC) begin
         n = i + 1;
         c = (i < s.size()) ? s[i] : 8'h00;
         lim = neg ? 64'sd2147483648 : 64'sd2147483647;
         if (nd > 0 && (c == 8'h0a || c == 8'h0d || c == 8'h20)) begin
            e = mag > lim;
            r = e ? (neg ? 32'h8000_0000 : 32'h7fff_ffff) : 32'(neg ? -mag : mag);
         end
      end
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   // gap: 0 back-to-back, 1 valid every other cycle, 2 random; pre: start already issued; chain: start on the done cycle
   task automatic run(input string tag, input bq_t s, input int gap, input bit pre, input bit chain, input bit mid_start);
      logic [31:0] er;
      logic        ee;
      int          en;
      int          idx;
      int          cyc;
      model(s, er, ee, en);
      if (!pre) begin
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk({tag, " busy"}, bus.busy, 1);
      chk({tag, " ready"}, bus.char_ready, 1);
      idx = 0;
      cyc = 1;
      while (!bus.done && cyc < 300) begin
         bus.char_valid = idx < s.size() && (gap == 0 || (gap == 1 ? cyc[0] : $urandom_range(0, 1) == 1));
         bus.char_data  = bus.char_valid ? s[idx] : 8'($urandom);
         bus.start      = mid_start && cyc == 2;
         if (bus.char_valid && bus.char_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.char_valid = 1'b0;
      bus.start      = 1'b0;
      chk({tag, " done"}, bus.done, 1);
      chk({tag, " rd"}, bus.rd, er);
      chk({tag, " err"}, bus.err, ee);
      chk({tag, " consumed"}, idx, en);
      if (gap == 0) chk({tag, " latency"}, cyc, en + 2);
      if (chain) begin
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         chk({tag, " chained done"}, bus.done, 0);
      end else begin
         @(negedge clk);
         chk({tag, " done pulse"}, bus.done, 0);
         chk({tag, " rd hold"}, bus.rd, er);
      end
   endtask
   initial begin
      bq_t q;
      int  r;
      compared       = 0;
      mismatched     = 0;
      reset          = 1'b1;
      bus.start      = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_data  = 8'h00;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      reset     = 1'b0;
      chk("rst rd", bus.rd, 0);
      chk("rst err", bus.err, 0);
      chk("rst done", bus.done, 0);
      chk("rst busy", bus.busy, 0);
      chk("rst ready", bus.char_ready, 0);
      run("123", str2q("123\n"), 0, 0, 0, 0);
      run("-45", str2q("  -45\015"), 1, 0, 0, 0);
      chk("-45 value", bus.rd, 32'hffff_ffd3);
      run("pos_ovf", str2q("2147483648\n"), 0, 0, 0, 0);
      run("neg_min", str2q("-2147483648\n"), 0, 0, 0, 0);
      run("neg_ovf", str2q("-99999999999\n"), 0, 0, 0, 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.char_valid = 1'b1;
      bus.char_data  = "7";
      @(negedge clk);
      bus.char_data = "8";
      @(negedge clk);
      bus.char_data = "9";
      reset         = 1'b1;
      @(negedge clk);
      reset          = 1'b0;
      bus.char_valid = 1'b0;
      chk("abort rd", bus.rd, 0);
      chk("abort err", bus.err, 0);
      chk("abort done", bus.done, 0);
      chk("abort busy", bus.busy, 0);
      chk("abort ready", bus.char_ready, 0);
      repeat (4) begin
         @(negedge clk);
         chk("abort no done", bus.done, 0);
      end
      run("after_rst", str2q("5\n"), 0, 0, 0, 1);
      run("12a", str2q("12a\n"), 0, 0, 0, 0);
      run("empty", str2q("\n"), 0, 0, 0, 0);
      run("sign_only", str2q("-\n"), 0, 0, 0, 0);
      run("len_limit", str2q("12345678901234567"), 0, 0, 0, 0);
      run("mid_start", str2q("57\n"), 0, 0, 0, 1);
      run("chain_a", str2q("9\n"), 0, 0, 1, 0);
      run("chain_b", str2q("\t-8 "), 0, 1, 0, 0);
      for (int k = 0; k < 40; k++) begin
         q = {};
         repeat ($urandom_range(0, 3)) q.push_back($urandom_range(0, 1) == 1 ? 8'h20 : 8'h09);
         r = int'($urandom_range(0, 2));
         if (r == 1) q.push_back("-");
         if (r == 2) q.push_back("+");
         repeat ($urandom_range(0, 12)) q.push_back(8'($urandom_range(48, 57)));
         r = int'($urandom_range(0, 7));
         q.push_back(r < 2 ? 8'h0a : r < 4 ? 8'h0d : r == 4 ? 8'h20 : r == 5 ? 8'h09 : 8'($urandom_range(33, 126)));
         q.push_back("Z");
         run($sformatf("rand%0d", k), q, k % 3, 0, 0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
